traffic_ctrl_param: RTL

//  Parametrised two-road intersection controller: main road A, side road B, vehicle sensors AS/BS.
//  Six-phase cycle with all-red clearance, internal tick prescaler, and per-road countdown displays.

---
 rtl/traffic_ctrl_param_if.sv | 23 ++
 rtl/traffic_ctrl_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_param_if.sv
// Sensor/lamp/display bundle between the intersection controller and the board.
// master = board side (drives sensors), slave = controller.
interface traffic_ctrl_param_if #(
    parameter int unsigned TW = 6
);
    logic          AS;
    logic          BS;
    logic          NIGHT;
    logic [2:0]    state;
    logic [5:0]    led;
    logic [TW-1:0] A_time;
    logic [TW-1:0] B_time;

    modport master (
        output AS, BS, NIGHT,
        input  state, led, A_time, B_time
    );

    modport slave (
        input  AS, BS, NIGHT,
        output state, led, A_time, B_time
    );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Two-road intersection controller: six-phase cycle, tick prescaler, countdown displays.
// Optional night flash mode is built when NIGHT_FLASH_EN is defined.
module traffic_ctrl_param #(
    parameter int unsigned TW       = 6,
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned AG_TIME  = 27,
    parameter int unsigned BG_TIME  = 17,
    parameter int unsigned Y_TIME   = 3,
    parameter int unsigned RR_TIME  = 1
) (
    input logic                 CLK,
    input logic                 RST,
    traffic_ctrl_param_if.slave bus
);
    localparam int unsigned XW       = TW + 2;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_I    = (2 ** TW) - 1;
    localparam int unsigned RST_B_I  = AG_TIME + Y_TIME + RR_TIME - 1;

    localparam logic [TW-1:0] AG_LOAD  = TW'(AG_TIME - 1);
    localparam logic [TW-1:0] BG_LOAD  = TW'(BG_TIME - 1);
    localparam logic [TW-1:0] Y_LOAD   = TW'(Y_TIME - 1);
    localparam logic [TW-1:0] RR_LOAD  = TW'(RR_TIME - 1);
    localparam logic [TW-1:0] RST_B    = (RST_B_I > MAX_I) ? TW'(MAX_I) : TW'(RST_B_I);

    localparam logic [XW-1:0] DISP_MAX = XW'(MAX_I);
    localparam logic [XW-1:0] ADD_YR   = XW'(Y_TIME + RR_TIME);
    localparam logic [XW-1:0] ADD_RR   = XW'(RR_TIME);
    localparam logic [XW-1:0] ADD_ARR  = XW'(BG_TIME + Y_TIME + RR_TIME);
    localparam logic [XW-1:0] ADD_BRR  = XW'(AG_TIME + Y_TIME + RR_TIME);

    localparam logic [5:0] LED_AG    = 6'b001100;
    localparam logic [5:0] LED_AY    = 6'b010100;
    localparam logic [5:0] LED_RR    = 6'b100100;
    localparam logic [5:0] LED_BG    = 6'b100001;
    localparam logic [5:0] LED_BY    = 6'b100010;
    localparam logic [5:0] LED_FLASH = 6'b010010;

    typedef enum logic [2:0] {
        S_AG    = 3'd0,
        S_AY    = 3'd1,
        S_ARR   = 3'd2,
        S_BG    = 3'd3,
        S_BY    = 3'd4,
        S_BRR   = 3'd5,
        S_FLASH = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q;
    logic          tick_c;
    logic [5:0]    led_q, led_d;
    logic [TW-1:0] a_q, a_d;
    logic [TW-1:0] b_q, b_d;
    logic [XW-1:0] a_x, b_x, cnt_x;
    logic          unused_inputs;

`ifdef NIGHT_FLASH_EN
    logic flash_q, flash_d;
    assign unused_inputs = bus.AS;
`else
    assign unused_inputs = &{1'b0, bus.AS, bus.NIGHT};
`endif

    // Prescaler: tick on the last count of each TICK_DIV window
    assign tick_c = (pre_q == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Phase sequencing; everything holds between ticks
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef NIGHT_FLASH_EN
        flash_d = flash_q;
`endif
        if (tick_c) begin
            case (state_q)
                S_AG: begin
                    if (cnt_q == '0) begin
                        if (bus.BS) begin
                            state_d = S_AY;
                            cnt_d   = Y_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                S_AY: begin
                    if (cnt_q == '0) begin
                        state_d = S_ARR;
                        cnt_d   = RR_LOAD;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                S_ARR: begin
                    if (cnt_q == '0) begin
                        state_d = S_BG;
                        cnt_d   = BG_LOAD;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                S_BG: begin
                    // Side road released early as soon as its queue empties
                    if (cnt_q == '0 || !bus.BS) begin
                        state_d = S_BY;
                        cnt_d   = Y_LOAD;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                S_BY: begin
                    if (cnt_q == '0) begin
                        state_d = S_BRR;
                        cnt_d   = RR_LOAD;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                S_BRR: begin
                    if (cnt_q == '0) begin
                        state_d = S_AG;
                        cnt_d   = AG_LOAD;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                default: begin
`ifdef NIGHT_FLASH_EN
                    if (bus.NIGHT) begin
                        flash_d = !flash_q;
                    end else begin
                        state_d = S_BRR;
                        cnt_d   = RR_LOAD;
                    end
`else
                    state_d = S_AG;
                    cnt_d   = AG_LOAD;
`endif
                end
            endcase
`ifdef NIGHT_FLASH_EN
            // Night request overrides any phase expiry
            if (bus.NIGHT && state_q != S_FLASH) begin
                state_d = S_FLASH;
                cnt_d   = '0;
                flash_d = 1'b1;
            end
`endif
        end
    end

    // Lamp and countdown decode from the next state so outputs move with state
    always_comb begin
        cnt_x = XW'(cnt_d);
        a_x   = cnt_x;
        b_x   = cnt_x;
        led_d = '0;
        case (state_d)
            S_AG: begin
                led_d = LED_AG;
                b_x   = cnt_x + ADD_YR;
            end
            S_AY: begin
                led_d = LED_AY;
                b_x   = cnt_x + ADD_RR;
            end
            S_ARR: begin
                led_d = LED_RR;
                a_x   = cnt_x + ADD_ARR;
            end
            S_BG: begin
                led_d = LED_BG;
                a_x   = cnt_x + ADD_YR;
            end
            S_BY: begin
                led_d = LED_BY;
                a_x   = cnt_x + ADD_RR;
            end
            S_BRR: begin
                led_d = LED_RR;
                b_x   = cnt_x + ADD_BRR;
            end
            default: begin
`ifdef NIGHT_FLASH_EN
                led_d = flash_d ? LED_FLASH : 6'b000000;
`else
                led_d = LED_FLASH;
`endif
                a_x   = '0;
                b_x   = '0;
            end
        endcase
        a_d = (a_x > DISP_MAX) ? DISP_MAX[TW-1:0] : a_x[TW-1:0];
        b_d = (b_x > DISP_MAX) ? DISP_MAX[TW-1:0] : b_x[TW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_AG;
            cnt_q   <= AG_LOAD;
            led_q   <= LED_AG;
            a_q     <= AG_LOAD;
            b_q     <= RST_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef NIGHT_FLASH_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            flash_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
        end
    end
`endif

    assign bus.state  = state_q;
    assign bus.led    = led_q;
    assign bus.A_time = a_q;
    assign bus.B_time = b_q;

endmodule
